// File: rtl/channelizer_m_core.sv
// Channelizer output stage: bin downselect, channel tagging and AXI-Stream packetization.
// Optional per-bin frame averaging is enabled by defining CHAN_AVG_EN.
module channelizer_m_core #(
    parameter int MAX_BINS = 256,
    parameter int DATA_W   = 16
) (
    input  logic                clk,
    input  logic                sync_reset,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    input  logic [2*DATA_W-1:0] s_axis_tdata,
    input  logic [31:0]         cfg_reload_data,
    input  logic                cfg_reload_update,
    input  logic                cfg_reload_last,
    input  logic [31:0]         cfg_downselect_data,
    input  logic                cfg_downselect_update,
    input  logic                cfg_downselect_last,
    input  logic [7:0]          cfg_fft_size,
    input  logic [8:0]          cfg_avg_len,
    input  logic [15:0]         cfg_payload_length,
    input  logic                cfg_chan_bypass,
    input  logic [7:0]          cfg_chan_first_num,
    output logic                eob_tag,
    output logic                first_channel,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic [2*DATA_W-1:0] m_axis_tdata,
    output logic [15:0]         m_axis_tuser,
    output logic                m_axis_tlast
);
    localparam int WORDS = MAX_BINS / 32;
    localparam int BIN_W = $clog2(MAX_BINS);
    localparam int LEN_W = BIN_W + 1;
    localparam int PTR_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [BIN_W-1:0]          bin_q, bin_d;
    logic [LEN_W-1:0]          frame_len_q, frame_len_d;
    logic [WORDS-1:0][31:0]    shadow_q, shadow_d;
    logic [MAX_BINS-1:0]       active_q, active_d;
    logic [PTR_W-1:0]          ptr_q, ptr_d;
    logic                      commit_q, commit_d;
    logic                      first_pend_q, first_pend_d;
    logic [15:0]               beat_q, beat_d;
    logic                      m_tvalid_q, m_tvalid_d;
    logic                      m_tlast_q, m_tlast_d;
    logic                      first_q, first_d;
    logic [2*DATA_W-1:0]       m_tdata_q, m_tdata_d;
    logic [15:0]               m_tuser_q, m_tuser_d;

    logic                      in_hs, out_hs, bin0, last_bin, mask_bit, kept, first_now, emit_ok;
    logic [LEN_W-1:0]          cfg_len, cur_len;
    logic [16:0]               pl_len;
    logic [15:0]               next_idx;
    logic [2*DATA_W-1:0]       sample;

    logic unused_reload;
    assign unused_reload = ^{cfg_reload_data, cfg_reload_update, cfg_reload_last};

`ifdef CHAN_AVG_EN
    localparam int ACC_W = DATA_W + 9;

    logic signed [ACC_W-1:0]   acc_i_mem [MAX_BINS];
    logic signed [ACC_W-1:0]   acc_q_mem [MAX_BINS];
    logic signed [ACC_W-1:0]   sum_i, sum_q, avg_i, avg_q;
    logic [8:0]                avg_idx_q, avg_idx_d, avg_len_q, avg_len_d, len_eff;
    logic [3:0]                shift;
    logic                      period_start, last_frame, acc_we;
    logic                      unused_avg;

    assign unused_avg = ^{avg_i[ACC_W-1:DATA_W], avg_q[ACC_W-1:DATA_W]};

    function automatic logic [3:0] log2_len(input logic [8:0] len);
        log2_len = '0;
        for (int i = 0; i < 9; i++)
            if (len[i]) log2_len = 4'(i);
    endfunction
`else
    logic unused_avg;
    assign unused_avg = ^cfg_avg_len;
`endif

    // NOTE: every variable gets a default before any branch so no path leaves it unassigned,
    // which is what keeps this block from inferring latches.
    always_comb begin
        in_hs     = s_axis_tvalid && s_axis_tready;
        out_hs    = m_tvalid_q && m_axis_tready;
        bin0      = (bin_q == '0);
        cfg_len   = (cfg_fft_size == 8'd0) ? LEN_W'(MAX_BINS) : LEN_W'(cfg_fft_size);
        cur_len   = bin0 ? cfg_len : frame_len_q;
        last_bin  = ({1'b0, bin_q} == cur_len - LEN_W'(1));
        // A commit pending at bin 0 takes effect for bin 0 itself.
        mask_bit  = (bin0 && commit_q) ? shadow_q[0][0] : active_q[bin_q];
        kept      = cfg_chan_bypass || mask_bit;
        first_now = bin0 || first_pend_q;
        pl_len    = (cfg_payload_length == 16'd0) ? 17'h10000 : {1'b0, cfg_payload_length};
        next_idx  = out_hs ? (m_tlast_q ? 16'd0 : beat_q + 16'd1) : beat_q;
        sample    = s_axis_tdata;
        emit_ok   = 1'b1;

`ifdef CHAN_AVG_EN
        period_start = bin0 && (avg_idx_q == '0);
        len_eff      = period_start ? cfg_avg_len : avg_len_q;
        last_frame   = (len_eff <= 9'd1) || (avg_idx_q == len_eff - 9'd1);
        sum_i        = ((avg_idx_q == '0) ? '0 : acc_i_mem[bin_q])
                       + ACC_W'(signed'(s_axis_tdata[DATA_W-1:0]));
        sum_q        = ((avg_idx_q == '0) ? '0 : acc_q_mem[bin_q])
                       + ACC_W'(signed'(s_axis_tdata[2*DATA_W-1:DATA_W]));
        shift        = log2_len(len_eff);
        avg_i        = sum_i >>> shift;
        avg_q        = sum_q >>> shift;
        sample       = {avg_q[DATA_W-1:0], avg_i[DATA_W-1:0]};
        emit_ok      = last_frame;
        acc_we       = in_hs;
        avg_idx_d    = avg_idx_q;
        avg_len_d    = avg_len_q;
        if (in_hs) begin
            if (period_start) avg_len_d = cfg_avg_len;
            if (last_bin)     avg_idx_d = last_frame ? 9'd0 : avg_idx_q + 9'd1;
        end
`endif

        bin_d        = bin_q;
        frame_len_d  = frame_len_q;
        shadow_d     = shadow_q;
        active_d     = active_q;
        ptr_d        = ptr_q;
        commit_d     = commit_q;
        first_pend_d = first_pend_q;
        beat_d       = next_idx;
        m_tvalid_d   = m_tvalid_q;
        m_tlast_d    = m_tlast_q;
        first_d      = first_q;
        m_tdata_d    = m_tdata_q;
        m_tuser_d    = m_tuser_q;

        if (in_hs) begin
            bin_d        = last_bin ? '0 : bin_q + 1'b1;
            first_pend_d = kept ? 1'b0 : first_now;
            if (bin0) begin
                frame_len_d = cfg_len;
                commit_d    = 1'b0;
                if (commit_q) active_d = shadow_q;
            end
        end

        if (cfg_downselect_update) begin
            shadow_d[ptr_q] = cfg_downselect_data;
            if (cfg_downselect_last) begin
                ptr_d    = '0;
                commit_d = 1'b1;
            end else begin
                ptr_d = (ptr_q == PTR_W'(WORDS - 1)) ? '0 : ptr_q + 1'b1;
            end
        end

        if (out_hs) m_tvalid_d = 1'b0;
        if (in_hs && kept && emit_ok) begin
            m_tvalid_d = 1'b1;
            m_tdata_d  = sample;
            m_tuser_d  = {8'd0, 8'(bin_q) + cfg_chan_first_num};
            m_tlast_d  = ({1'b0, next_idx} == pl_len - 17'd1);
            first_d    = first_now;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            bin_q        <= '0;
            frame_len_q  <= LEN_W'(MAX_BINS);
            shadow_q     <= '1;
            active_q     <= '1;
            ptr_q        <= '0;
            commit_q     <= 1'b0;
            first_pend_q <= 1'b1;
            beat_q       <= '0;
            m_tvalid_q   <= 1'b0;
            m_tlast_q    <= 1'b0;
            first_q      <= 1'b0;
            m_tdata_q    <= '0;
            m_tuser_q    <= '0;
        end else begin
            bin_q        <= bin_d;
            frame_len_q  <= frame_len_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            ptr_q        <= ptr_d;
            commit_q     <= commit_d;
            first_pend_q <= first_pend_d;
            beat_q       <= beat_d;
            m_tvalid_q   <= m_tvalid_d;
            m_tlast_q    <= m_tlast_d;
            first_q      <= first_d;
            m_tdata_q    <= m_tdata_d;
            m_tuser_q    <= m_tuser_d;
        end
    end

`ifdef CHAN_AVG_EN
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            avg_idx_q <= '0;
            avg_len_q <= 9'd1;
        end else begin
            avg_idx_q <= avg_idx_d;
            avg_len_q <= avg_len_d;
        end
    end

    // NOTE: the accumulator RAM has no reset; the first frame of every period overwrites it.
    always_ff @(posedge clk) begin
        if (acc_we) begin
            acc_i_mem[bin_q] <= sum_i;
            acc_q_mem[bin_q] <= sum_q;
        end
    end
`endif

    assign s_axis_tready = !m_tvalid_q || m_axis_tready;
    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tuser  = m_tuser_q;
    assign m_axis_tlast  = m_tlast_q;
    assign first_channel = first_q;
    assign eob_tag       = m_tvalid_q && m_axis_tready && m_tlast_q;
endmodule

// File: tb/tb_channelizer_m_core.sv
// Directed-vector bench for channelizer_m_core: bypass ramp, masked bins, mid-frame mask
// reload, packet boundaries, output backpressure and (with CHAN_AVG_EN) frame averaging.
module tb_channelizer_m_core;
    logic        clk = 1'b0;
    logic        sync_reset;
    logic        s_axis_tvalid, s_axis_tready;
    logic [31:0] s_axis_tdata;
    logic [31:0] cfg_reload_data, cfg_downselect_data;
    logic        cfg_reload_update, cfg_reload_last, cfg_downselect_update, cfg_downselect_last;
    logic [7:0]  cfg_fft_size, cfg_chan_first_num;
    logic [8:0]  cfg_avg_len;
    logic [15:0] cfg_payload_length;
    logic        cfg_chan_bypass;
    logic        eob_tag, first_channel, m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [31:0] m_axis_tdata;
    logic [15:0] m_axis_tuser;

    channelizer_m_core dut (
        .clk                  (clk),
        .sync_reset           (sync_reset),
        .s_axis_tvalid        (s_axis_tvalid),
        .s_axis_tready        (s_axis_tready),
        .s_axis_tdata         (s_axis_tdata),
        .cfg_reload_data      (cfg_reload_data),
        .cfg_reload_update    (cfg_reload_update),
        .cfg_reload_last      (cfg_reload_last),
        .cfg_downselect_data  (cfg_downselect_data),
        .cfg_downselect_update(cfg_downselect_update),
        .cfg_downselect_last  (cfg_downselect_last),
        .cfg_fft_size         (cfg_fft_size),
        .cfg_avg_len          (cfg_avg_len),
        .cfg_payload_length   (cfg_payload_length),
        .cfg_chan_bypass      (cfg_chan_bypass),
        .cfg_chan_first_num   (cfg_chan_first_num),
        .eob_tag              (eob_tag),
        .first_channel        (first_channel),
        .m_axis_tvalid        (m_axis_tvalid),
        .m_axis_tready        (m_axis_tready),
        .m_axis_tdata         (m_axis_tdata),
        .m_axis_tuser         (m_axis_tuser),
        .m_axis_tlast         (m_axis_tlast)
    );

    always #5 clk = ~clk;

    typedef logic [49:0] beat_t;  // {tlast, first_channel, tuser, tdata}

    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          exp_beat, pl, fn, stall_cnt;
    bit          toggle_en, use_const, hold_v;
    logic [31:0] const_val;
    logic [48:0] held;
    logic [31:0] upd_words [4];
    beat_t       exp_q [$];
    beat_t       got_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int f, input int b);
        return {8'(f), 8'(b), 16'(b) ^ 16'h5A00};
    endfunction

    always @(posedge clk) cyc++;

    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1 m_axis_tready = toggle_en ? ~m_axis_tready : 1'b1;
        end
    end

    // Output monitor: records accepted beats and checks stall behaviour mid-cycle.
    always @(negedge clk) begin
        if (sync_reset) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v)
                check("hold", 64'({m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata}),
                      64'({1'b1, held}));
            hold_v = m_axis_tvalid && !m_axis_tready;
            if (hold_v) begin
                held = {m_axis_tlast, m_axis_tuser, m_axis_tdata};
                stall_cnt++;
                check("s_tready_stall", 64'(s_axis_tready), 64'(1'b0));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                got_q.push_back({m_axis_tlast, first_channel, m_axis_tuser, m_axis_tdata});
                check("eob", 64'(eob_tag), 64'(m_axis_tlast));
            end else if (eob_tag) begin
                check("eob_stray", 64'(eob_tag), 64'(1'b0));
            end
        end
    end

    task automatic do_reset();
        sync_reset            = 1'b1;
        s_axis_tvalid         = 1'b0;
        s_axis_tdata          = '0;
        cfg_reload_data       = '0;
        cfg_reload_update     = 1'b0;
        cfg_reload_last       = 1'b0;
        cfg_downselect_data   = '0;
        cfg_downselect_update = 1'b0;
        cfg_downselect_last   = 1'b0;
        cfg_avg_len           = 9'd1;
        cfg_chan_bypass       = 1'b0;
        toggle_en             = 1'b0;
        use_const             = 1'b0;
        repeat (3) @(posedge clk);
        #1 sync_reset = 1'b0;
        exp_beat  = 0;
        stall_cnt = 0;
    endtask

    task automatic load_mask(input int nw);
        for (int i = 0; i < nw; i++) begin
            cfg_downselect_update = 1'b1;
            cfg_downselect_data   = upd_words[i];
            cfg_downselect_last   = (i == nw - 1);
            @(posedge clk);
            #1;
        end
        cfg_downselect_update = 1'b0;
        cfg_downselect_last   = 1'b0;
    endtask

    task automatic send_bin(input logic [31:0] d, input bit upd, input logic [31:0] w,
                            input bit wl);
        bit hs;
        hs                    = 1'b0;
        s_axis_tvalid         = 1'b1;
        s_axis_tdata          = d;
        cfg_downselect_update = upd;
        cfg_downselect_data   = w;
        cfg_downselect_last   = wl;
        for (int t = 0; t < 50 && !hs; t++) begin
            @(negedge clk);
            hs = s_axis_tready;
            @(posedge clk);
            #1;
            cfg_downselect_update = 1'b0;
            cfg_downselect_last   = 1'b0;
        end
        if (!hs) check("s_hs_timeout", 64'(hs), 64'(1'b1));
    endtask

    task automatic send_frame(input int f, input int n, input logic [255:0] keep,
                              input int upd_at, input int nw, input bit lat_chk);
        bit first;
        int pl_eff;
        first  = 1'b1;
        pl_eff = (pl == 0) ? 65536 : pl;
        for (int b = 0; b < n; b++) begin
            logic [31:0] d;
            bit          upd, lst;
            d   = use_const ? const_val : pat(f, b);
            upd = (upd_at >= 0) && (b >= upd_at) && (b < upd_at + nw);
            if (keep[b]) begin
                lst = ((exp_beat % pl_eff) == pl_eff - 1);
                exp_q.push_back({lst, first, 8'd0, 8'(b + fn), d});
                first = 1'b0;
                exp_beat++;
            end
            send_bin(d, upd, upd ? upd_words[b - upd_at] : 32'd0, upd && (b - upd_at == nw - 1));
            if (lat_chk && b == 0) begin
                check("lat_valid", 64'(m_axis_tvalid), 64'(1'b1));
                check("lat_tuser", 64'(m_axis_tuser), 64'(16'(fn)));
                check("lat_first", 64'(first_channel), 64'(1'b1));
            end
        end
    endtask

    task automatic drain_and_compare(input string tag);
        s_axis_tvalid = 1'b0;
        for (int t = 0; t < 2000 && got_q.size() < exp_q.size(); t++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check(tag, 64'(got_q[i]), 64'(exp_q[i]));
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        logic [255:0] keep_all, keep_a, keep_b, keep_c, keep_8;
        int           c0;
        keep_all = '1;
        keep_a = '0; keep_a[3:0] = 4'hF; keep_a[127] = 1'b1;
        keep_b = '0; keep_b[5:4] = 2'b11;
        keep_c = '0; keep_c[0] = 1'b1;
        keep_8 = '0; keep_8[7:0] = 8'hFF;

        // Reset state.
        pl = 0; fn = 0;
        cfg_payload_length = 16'd0;
        cfg_chan_first_num = 8'd0;
        cfg_fft_size       = 8'd128;
        do_reset();
        check("rst_tvalid", 64'(m_axis_tvalid), 64'(1'b0));
        check("rst_tlast",  64'(m_axis_tlast),  64'(1'b0));
        check("rst_eob",    64'(eob_tag),       64'(1'b0));
        check("rst_first",  64'(first_channel), 64'(1'b0));
        check("rst_tdata",  64'(m_axis_tdata),  64'(32'd0));
        check("rst_tuser",  64'(m_axis_tuser),  64'(16'd0));
        check("rst_sready", 64'(s_axis_tready), 64'(1'b1));

        // Bypass ramp, 128 bins, one-cycle latency.
        cfg_chan_bypass = 1'b1;
        send_frame(0, 128, keep_all, -1, 0, 1'b1);
        drain_and_compare("bypass_ramp");

        // Mask load ahead of the stream, channel offset 10.
        do_reset();
        fn = 10; cfg_chan_first_num = 8'd10;
        upd_words[0] = 32'h0000_000F; upd_words[1] = 32'h0;
        upd_words[2] = 32'h0;         upd_words[3] = 32'h8000_0000;
        load_mask(4);
        send_frame(0, 128, keep_a, -1, 0, 1'b0);
        send_frame(1, 128, keep_a, -1, 0, 1'b0);
        drain_and_compare("mask_load");

        // Mid-frame reload keeps the old mask; a reload on bin 0 waits one more frame.
        upd_words[0] = 32'h0000_0030; upd_words[1] = 32'h0;
        upd_words[2] = 32'h0;         upd_words[3] = 32'h0;
        send_frame(2, 128, keep_a, 50, 4, 1'b0);
        send_frame(3, 128, keep_b, -1, 0, 1'b0);
        upd_words[0] = 32'h0000_0001;
        send_frame(4, 128, keep_b, 0, 1, 1'b0);
        send_frame(5, 128, keep_c, -1, 0, 1'b0);
        drain_and_compare("mask_swap");

        // Packets of 16 beats over frames of 8 kept bins; dropped bins cost one cycle each.
        do_reset();
        fn = 0; cfg_chan_first_num = 8'd0;
        pl = 16; cfg_payload_length = 16'd16;
        cfg_fft_size = 8'd16;
        upd_words[0] = 32'h0000_00FF;
        load_mask(1);
        c0 = cyc;
        send_frame(0, 16, keep_8, -1, 0, 1'b0);
        check("drop_rate", 64'(cyc - c0), 64'(16));
        for (int f = 1; f < 4; f++) send_frame(f, 16, keep_8, -1, 0, 1'b0);
        drain_and_compare("packets");

        // 256-bin frames (size 0) under 50% output backpressure.
        do_reset();
        pl = 100; cfg_payload_length = 16'd100;
        cfg_fft_size = 8'd0;
        cfg_chan_bypass = 1'b1;
        toggle_en = 1'b1;
        send_frame(0, 256, keep_all, -1, 0, 1'b0);
        send_frame(1, 4, keep_all, -1, 0, 1'b0);
        drain_and_compare("backpressure");
        check("stalls_seen", 64'(stall_cnt > 0), 64'(1'b1));
        toggle_en = 1'b0;

`ifdef CHAN_AVG_EN
        // Averaging over 4 frames of a constant bin value.
        do_reset();
        pl = 0; cfg_payload_length = 16'd0;
        cfg_fft_size = 8'd8;
        cfg_chan_bypass = 1'b1;
        cfg_avg_len = 9'd4;
        use_const = 1'b1;
        const_val = 32'h0100_0200;
        for (int f = 0; f < 8; f++)
            send_frame(f, 8, (f % 4 == 3) ? keep_8 : 256'd0, -1, 0, 1'b0);
        drain_and_compare("average");
        use_const = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
